sevenseg_capture: RTL

//  Receiver for the multiplexed 7-segment interface: samples seg/an, rebuilds the
//  8 digit codes (same 5-bit code space as the display driver) plus decimal points.

---
 rtl/sevenseg_capture.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sevenseg_capture.sv
// Multiplexed 7-segment receiver: syncs seg/an, waits for a settled digit,
// decodes it into the display code space and tracks frames and errors.
module sevenseg_capture #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg,
  input  logic [7:0]  an,
  input  logic        clr_err,
  output logic [39:0] digits,
  output logic [7:0]  dp_out,
  output logic [7:0]  slot_valid,
  output logic        frame_done,
  output logic        err_pattern,
  output logic        err_anode
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);
  localparam logic [39:0] DIG_RST = {8{5'h1d}};

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } state_t;

  logic [7:0]    seg_m_q, seg_s_q;
  logic [7:0]    an_m_q, an_s_q;
  logic [15:0]   prev_q, prev_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [39:0]   digits_q, digits_d;
  logic [7:0]    dp_q, dp_d;
  logic [7:0]    valid_q, valid_d;
  logic [7:0]    mask_q, mask_d;
  logic          frame_q, frame_d;
  logic          errp_q, errp_d;
  logic          erra_q, erra_d;

  logic          onehot, multi, lit, changed, wr, full;
  logic [2:0]    slot;
  logic [7:0]    slot_bit;
  logic [5:0]    dec;
  logic [5:0]    base;

  // Returns {bad, code}; p is active-high {g..a}.
  function automatic logic [5:0] decode(
    input logic [6:0] p,
    input logic       dp
  );
    logic [5:0] r;
    r = 6'h00;
    case (p)
      7'h3F: r = 6'h00;
      7'h06: r = 6'h01;
      7'h5B: r = 6'h02;
      7'h4F: r = 6'h03;
      7'h66: r = 6'h04;
      7'h6D: r = 6'h05;
      7'h7D: r = 6'h06;
      7'h07: r = 6'h07;
      7'h7F: r = 6'h08;
      7'h6F: r = 6'h09;
      7'h77: r = 6'h0A;
      7'h7C: r = 6'h0B;
      7'h39: r = 6'h0C;
      7'h5E: r = 6'h0D;
      7'h79: r = 6'h0E;
      7'h71: r = 6'h0F;
      7'h01: r = 6'h10;
      7'h02: r = 6'h11;
      7'h04: r = 6'h12;
      7'h08: r = 6'h13;
      7'h10: r = 6'h14;
      7'h20: r = 6'h15;
      7'h40: r = 6'h16;
      7'h76: r = 6'h18;
      7'h38: r = 6'h19;
      7'h31: r = 6'h1A;
      7'h30: r = 6'h1B;
      7'h50: r = 6'h1C;
      7'h00: r = dp ? 6'h17 : 6'h1D;
      default: r = 6'h3F;
    endcase
    return r;
  endfunction

  always_comb begin
    onehot  = $onehot(~an_s_q);
    multi   = $countones(~an_s_q) > 1;
    lit     = seg_s_q != 8'hFF;
    changed = {seg_s_q, an_s_q} != prev_q;
    dec     = decode(~seg_s_q[6:0], ~seg_s_q[7]);
  end

  always_comb begin
    slot = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an_s_q[i]) slot = 3'(i);
    end
    slot_bit = 8'h01 << slot;
    base     = 6'(slot) * 6'd5;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr      = 1'b0;
    erra_d  = erra_q & ~clr_err;
    if (!onehot) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (multi && lit) erra_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end
        SETTLE: begin
          if (changed) begin
            cnt_d = CW'(1);
          end else if (cnt_q >= CNT_MAX) begin
            wr      = 1'b1;
            state_d = CAPTURED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CAPTURED: begin
          if (changed) begin
            state_d = SETTLE;
            cnt_d   = CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    prev_d   = {seg_s_q, an_s_q};
    digits_d = digits_q;
    dp_d     = dp_q;
    valid_d  = valid_q;
    mask_d   = mask_q;
    frame_d  = 1'b0;
    full     = (mask_q | slot_bit) == 8'hFF;
    errp_d   = errp_q & ~clr_err;
    if (wr) begin
      digits_d[base +: 5] = dec[4:0];
      dp_d[slot]    = ~seg_s_q[7];
      valid_d[slot] = 1'b1;
      // Frame completes on the write that fills the last slot.
      mask_d  = full ? 8'h00 : (mask_q | slot_bit);
      frame_d = full;
      if (dec[5]) errp_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_m_q  <= 8'hFF;
      seg_s_q  <= 8'hFF;
      an_m_q   <= 8'hFF;
      an_s_q   <= 8'hFF;
      prev_q   <= 16'hFFFF;
      state_q  <= IDLE;
      cnt_q    <= '0;
      digits_q <= DIG_RST;
      dp_q     <= 8'h00;
      valid_q  <= 8'h00;
      mask_q   <= 8'h00;
      frame_q  <= 1'b0;
      errp_q   <= 1'b0;
      erra_q   <= 1'b0;
    end else begin
      seg_m_q  <= seg;
      seg_s_q  <= seg_m_q;
      an_m_q   <= an;
      an_s_q   <= an_m_q;
      prev_q   <= prev_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      dp_q     <= dp_d;
      valid_q  <= valid_d;
      mask_q   <= mask_d;
      frame_q  <= frame_d;
      errp_q   <= errp_d;
      erra_q   <= erra_d;
    end
  end

  assign digits      = digits_q;
  assign dp_out      = dp_q;
  assign slot_valid  = valid_q;
  assign frame_done  = frame_q;
  assign err_pattern = errp_q;
  assign err_anode   = erra_q;

endmodule
